// File: rtl/rv_mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package rv_mem_arb_pkg;

  localparam int MEM_RD_LATENCY = 1;
  localparam int PKG_ADDR_W     = 32;
  localparam int PKG_DATA_W     = 32;

  // Owner of the read currently in flight to the memory.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } rsp_owner_t;

  // Memory request payload at the default core widths.
  typedef struct packed {
    logic [PKG_ADDR_W-1:0]   addr;
    logic                    we;
    logic [PKG_DATA_W/8-1:0] be;
    logic [PKG_DATA_W-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/rv_mem_arb_starve.sv
// Saturating count of consecutive cycles the fetch requester lost arbitration.
module rv_mem_arb_starve
  import rv_mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear wins over increment; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != 4'(MAX_STARVE))) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == 4'(MAX_STARVE));

endmodule

// File: rtl/rv_mem_arb.sv
// Fetch/data arbiter for one single-port memory with 1-cycle read latency.
// Data wins unless fetch has starved MAX_STARVE cycles in a row.
// Optional grant/conflict statistics ports: define RV_MEM_ARB_STATS_EN.
module rv_mem_arb
  import rv_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                dm_req_valid,
  output logic                dm_req_ready,
  input  logic [ADDR_W-1:0]   dm_req_addr,
  input  logic                dm_req_we,
  input  logic [DATA_W/8-1:0] dm_req_be,
  input  logic [DATA_W-1:0]   dm_req_wdata,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W/8-1:0] mem_req_be,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic [DATA_W-1:0]   mem_rsp_data
`ifdef RV_MEM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_if_gnt,
  output logic [31:0]         stat_dm_gnt,
  output logic [31:0]         stat_conflict
`endif
);

  localparam int BE_W = DATA_W / 8;

  // Request bundle sized to this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_bus_t;

  logic       gnt_if_s;
  logic       gnt_dm_s;
  logic       at_max_s;
  req_bus_t   mem_req_s;
  rsp_owner_t owner_q;
  rsp_owner_t owner_d;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] if_data_d;
  logic [DATA_W-1:0] dm_data_q;
  logic [DATA_W-1:0] dm_data_d;

  // Grant decision and request mux; outputs are zero when nothing is granted.
  always_comb begin
    gnt_dm_s  = 1'b0;
    gnt_if_s  = 1'b0;
    mem_req_s = '0;
    if (mem_req_ready) begin
      gnt_dm_s = dm_req_valid && !(if_req_valid && at_max_s);
      gnt_if_s = if_req_valid && !gnt_dm_s;
    end else begin
      gnt_dm_s = 1'b0;
      gnt_if_s = 1'b0;
    end
    if (gnt_dm_s) begin
      mem_req_s.addr  = dm_req_addr;
      mem_req_s.we    = dm_req_we;
      mem_req_s.be    = dm_req_be;
      mem_req_s.wdata = dm_req_wdata;
    end else if (gnt_if_s) begin
      mem_req_s.addr  = if_req_addr;
      mem_req_s.we    = 1'b0;
      mem_req_s.be    = {BE_W{1'b1}};
      mem_req_s.wdata = '0;
    end else begin
      mem_req_s = '0;
    end
  end

  assign if_req_ready  = gnt_if_s;
  assign dm_req_ready  = gnt_dm_s;
  assign mem_req_valid = gnt_if_s || gnt_dm_s;
  assign mem_req_addr  = mem_req_s.addr;
  assign mem_req_we    = mem_req_s.we;
  assign mem_req_be    = mem_req_s.be;
  assign mem_req_wdata = mem_req_s.wdata;

  rv_mem_arb_starve #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (gnt_dm_s && if_req_valid),
    .clr    (gnt_if_s || !if_req_valid),
    .at_max (at_max_s)
  );

  // Next owner of the returning read, plus data hold for the non-owner.
  always_comb begin
    owner_d   = OWN_NONE;
    if_data_d = if_data_q;
    dm_data_d = dm_data_q;
    if (gnt_if_s) begin
      owner_d = OWN_IF;
    end else if (gnt_dm_s && !dm_req_we) begin
      owner_d = OWN_DM;
    end else begin
      owner_d = OWN_NONE;
    end
    case (owner_q)
      OWN_IF:  if_data_d = mem_rsp_data;
      OWN_DM:  dm_data_d = mem_rsp_data;
      default: begin
        if_data_d = if_data_q;
        dm_data_d = dm_data_q;
      end
    endcase
  end

  // Owner FSM and held response data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      owner_q   <= owner_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
    end
  end

  // Read data is only valid the cycle after the grant, so data passes through.
  assign if_rsp_valid = (owner_q == OWN_IF);
  assign dm_rsp_valid = (owner_q == OWN_DM);
  assign if_rsp_data  = (owner_q == OWN_IF) ? mem_rsp_data : if_data_q;
  assign dm_rsp_data  = (owner_q == OWN_DM) ? mem_rsp_data : dm_data_q;

`ifdef RV_MEM_ARB_STATS_EN
  logic [31:0] stat_if_q, stat_if_d;
  logic [31:0] stat_dm_q, stat_dm_d;
  logic [31:0] stat_cf_q, stat_cf_d;

  // Wrapping grant and conflict counters.
  always_comb begin
    stat_if_d = stat_if_q;
    stat_dm_d = stat_dm_q;
    stat_cf_d = stat_cf_q;
    if (gnt_if_s) begin
      stat_if_d = stat_if_q + 32'd1;
    end else begin
      stat_if_d = stat_if_q;
    end
    if (gnt_dm_s) begin
      stat_dm_d = stat_dm_q + 32'd1;
    end else begin
      stat_dm_d = stat_dm_q;
    end
    if (if_req_valid && dm_req_valid && mem_req_ready) begin
      stat_cf_d = stat_cf_q + 32'd1;
    end else begin
      stat_cf_d = stat_cf_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_if_q <= 32'd0;
      stat_dm_q <= 32'd0;
      stat_cf_q <= 32'd0;
    end else begin
      stat_if_q <= stat_if_d;
      stat_dm_q <= stat_dm_d;
      stat_cf_q <= stat_cf_d;
    end
  end

  assign stat_if_gnt   = stat_if_q;
  assign stat_dm_gnt   = stat_dm_q;
  assign stat_conflict = stat_cf_q;
`endif

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed self-checking bench for rv_mem_arb with a small memory model.
module tb_rv_mem_arb;
  import rv_mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_req_addr = 32'd0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid = 1'b0;
  logic        dm_req_ready;
  logic [31:0] dm_req_addr = 32'd0;
  logic        dm_req_we = 1'b0;
  logic [3:0]  dm_req_be = 4'd0;
  logic [31:0] dm_req_wdata = 32'd0;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic [31:0] mem_rsp_data;
`ifdef RV_MEM_ARB_STATS_EN
  logic [31:0] stat_if_gnt;
  logic [31:0] stat_dm_gnt;
  logic [31:0] stat_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  logic [31:0] rd_q;

  always #5 clk = ~clk;

  rv_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_req_we(dm_req_we), .dm_req_be(dm_req_be), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_data(mem_rsp_data)
`ifdef RV_MEM_ARB_STATS_EN
    , .stat_if_gnt(stat_if_gnt), .stat_dm_gnt(stat_dm_gnt), .stat_conflict(stat_conflict)
`endif
  );

  // Memory model: word i resets to 0x10000000 + i; reads return one cycle later.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      rd_q <= 32'd0;
    end else if (mem_req_valid && mem_req_ready) begin
      if (mem_req_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_req_be[b]) mem[mem_req_addr[9:2]][b*8 +: 8] <= mem_req_wdata[b*8 +: 8];
      end else begin
        rd_q <= mem[mem_req_addr[9:2]];
      end
    end
  end
  assign mem_rsp_data = rd_q;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    next_cycle();
    next_cycle();
    #4;
    n_checks++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_rsp_valid got %0b exp 0", if_rsp_valid); end
    n_checks++; if (dm_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dm_rsp_valid got %0b exp 0", dm_rsp_valid); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_valid got %0b exp 0", mem_req_valid); end
    n_checks++; if (mem_req_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mem_req_addr got %h exp 0", mem_req_addr); end
    n_checks++; if (dut.owner_q !== OWN_NONE) begin n_fail++; $display("FAIL rst_owner got %0d exp 0", dut.owner_q); end
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_if_stream;
    logic [31:0] exp_data [0:2];
    exp_data[0] = 32'h1000_0000;
    exp_data[1] = 32'h1000_0001;
    exp_data[2] = 32'h1000_0002;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      if_req_valid = (c < 3);
      if_req_addr  = 32'(c * 4);
      #4;
      if (c < 3) begin
        n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL if_ready c%0d got %0b exp 1", c, if_req_ready); end
        n_checks++; if (mem_req_addr !== 32'(c * 4)) begin n_fail++; $display("FAIL if_addr c%0d got %h exp %h", c, mem_req_addr, c * 4); end
        n_checks++; if ({mem_req_we, mem_req_be} !== 5'b0_1111) begin n_fail++; $display("FAIL if_we_be c%0d got %b exp 01111", c, {mem_req_we, mem_req_be}); end
      end
      if (c > 0) begin
        n_checks++; if (if_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL if_rsp_valid c%0d got %0b exp 1", c, if_rsp_valid); end
        n_checks++; if (if_rsp_data !== exp_data[c-1]) begin n_fail++; $display("FAIL if_rsp_data c%0d got %h exp %h", c, if_rsp_data, exp_data[c-1]); end
      end
    end
    next_cycle();
    #4;
    n_checks++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL if_rsp_idle got %0b exp 0", if_rsp_valid); end
  endtask

  task automatic test_arbitration;
    logic [9:0] exp_if;
    exp_if = 10'b10_0001_0000;  // IF wins cycles 4 and 9
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    if_req_addr  = 32'h20;
    dm_req_addr  = 32'h10;
    dm_req_we    = 1'b0;
    dm_req_be    = 4'hF;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if_req_valid = 1'b1;
      dm_req_valid = 1'b1;
      #4;
      n_checks++; if (if_req_ready !== exp_if[i]) begin n_fail++; $display("FAIL arb_if_ready c%0d got %0b exp %0b", i, if_req_ready, exp_if[i]); end
      n_checks++; if (dm_req_ready !== !exp_if[i]) begin n_fail++; $display("FAIL arb_dm_ready c%0d got %0b exp %0b", i, dm_req_ready, !exp_if[i]); end
      if (i > 0) begin
        if (exp_if[i-1]) begin
          n_checks++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h1000_0008}) begin n_fail++; $display("FAIL arb_if_rsp c%0d got %0b/%h exp 1/10000008", i, if_rsp_valid, if_rsp_data); end
        end else begin
          n_checks++; if ({dm_rsp_valid, dm_rsp_data} !== {1'b1, 32'h1000_0004}) begin n_fail++; $display("FAIL arb_dm_rsp c%0d got %0b/%h exp 1/10000004", i, dm_rsp_valid, dm_rsp_data); end
        end
      end
      if (i == 4) begin
        n_checks++; if (dut.u_starve.cnt_q !== 4'd4) begin n_fail++; $display("FAIL starve_max got %0d exp 4", dut.u_starve.cnt_q); end
      end
      if (i == 5) begin
        n_checks++; if (dut.u_starve.cnt_q !== 4'd0) begin n_fail++; $display("FAIL starve_clr got %0d exp 0", dut.u_starve.cnt_q); end
      end
    end
    next_cycle();
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    #4;
    n_checks++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL arb_last_rsp got %b exp 10", {if_rsp_valid, dm_rsp_valid}); end
`ifdef RV_MEM_ARB_STATS_EN
    n_checks++; if (stat_dm_gnt !== 32'd8) begin n_fail++; $display("FAIL stat_dm got %0d exp 8", stat_dm_gnt); end
    n_checks++; if (stat_if_gnt !== 32'd2) begin n_fail++; $display("FAIL stat_if got %0d exp 2", stat_if_gnt); end
    n_checks++; if (stat_conflict !== 32'd10) begin n_fail++; $display("FAIL stat_conflict got %0d exp 10", stat_conflict); end
`endif
  endtask

  task automatic test_write_read;
    next_cycle();
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b1;
    dm_req_addr  = 32'h100;
    dm_req_be    = 4'b0011;
    dm_req_wdata = 32'hDEAD_BEEF;
    #4;
    n_checks++; if (dm_req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready got %0b exp 1", dm_req_ready); end
    n_checks++; if ({mem_req_we, mem_req_be} !== 5'b1_0011) begin n_fail++; $display("FAIL wr_we_be got %b exp 10011", {mem_req_we, mem_req_be}); end
    n_checks++; if (mem_req_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata got %h exp deadbeef", mem_req_wdata); end
    next_cycle();
    dm_req_we = 1'b0;
    dm_req_be = 4'hF;
    #4;
    n_checks++; if (dm_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp got %0b exp 0", dm_rsp_valid); end
    n_checks++; if (mem_req_we !== 1'b0) begin n_fail++; $display("FAIL rd_we got %0b exp 0", mem_req_we); end
    next_cycle();
    dm_req_valid = 1'b0;
    #4;
    n_checks++; if ({dm_rsp_valid, dm_rsp_data} !== {1'b1, 32'h1000_BEEF}) begin n_fail++; $display("FAIL rd_rsp got %0b/%h exp 1/1000beef", dm_rsp_valid, dm_rsp_data); end
    n_checks++; if ({if_rsp_valid, if_rsp_data} !== {1'b0, 32'h1000_0008}) begin n_fail++; $display("FAIL if_hold got %0b/%h exp 0/10000008", if_rsp_valid, if_rsp_data); end
  endtask

  task automatic test_stall;
    next_cycle();
    if_req_valid = 1'b1;
    dm_req_valid = 1'b1;
    if_req_addr  = 32'h20;
    dm_req_addr  = 32'h10;
    #4;
    n_checks++; if (dm_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_pre got %0b exp 1", dm_req_ready); end
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      mem_req_ready = 1'b0;
      #4;
      n_checks++; if ({if_req_ready, dm_req_ready, mem_req_valid} !== 3'b000) begin n_fail++; $display("FAIL stall_gnt s%0d got %b exp 000", s, {if_req_ready, dm_req_ready, mem_req_valid}); end
      n_checks++; if (dut.u_starve.cnt_q !== 4'd1) begin n_fail++; $display("FAIL stall_cnt s%0d got %0d exp 1", s, dut.u_starve.cnt_q); end
      if (s > 0) begin
        n_checks++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL stall_rsp s%0d got %b exp 00", s, {if_rsp_valid, dm_rsp_valid}); end
      end
    end
    next_cycle();
    mem_req_ready = 1'b1;
    #4;
    n_checks++; if ({if_req_ready, dm_req_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_resume got %b exp 01", {if_req_ready, dm_req_ready}); end
    next_cycle();
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
  endtask

  task automatic test_reset_inflight;
    next_cycle();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h04;
    #4;
    n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL rsti_gnt got %0b exp 1", if_req_ready); end
    next_cycle();
    rst          = 1'b0;
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b0;
    #4;
    n_checks++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h1000_0001}) begin n_fail++; $display("FAIL rsti_rsp got %0b/%h exp 1/10000001", if_rsp_valid, if_rsp_data); end
    next_cycle();
    rst          = 1'b1;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    #4;
    n_checks++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rsti_valid got %b exp 00", {if_rsp_valid, dm_rsp_valid}); end
    n_checks++; if (dut.u_starve.cnt_q !== 4'd0) begin n_fail++; $display("FAIL rsti_cnt got %0d exp 0", dut.u_starve.cnt_q); end
    n_checks++; if (dut.owner_q !== OWN_NONE) begin n_fail++; $display("FAIL rsti_owner got %0d exp 0", dut.owner_q); end
  endtask

  initial begin
    test_reset();
    test_if_stream();
    test_arbitration();
    test_write_read();
    test_stall();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Arbitrates a single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MA stage) of the 5-stage core.
- Sits inside the memory wrapper, between the core request/response channels and one memory port with fixed 1-cycle read latency.
- Data requests take priority. A starvation counter guarantees fetch progress.
- Tracks ownership of the outstanding read and routes the returning data to the correct requester.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_STARVE, 4, number of consecutive lost fetch cycles after which fetch is granted regardless of a data request; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch read data valid
- if_rsp_data  out  DATA_W  fetch read data
- dm_req_valid  in  1  data request valid
- dm_req_ready  out  1  data request accepted this cycle
- dm_req_addr  in  ADDR_W  data address
- dm_req_we  in  1  1 = write, 0 = read
- dm_req_be  in  DATA_W/8  write byte enables
- dm_req_wdata  in  DATA_W  write data
- dm_rsp_valid  out  1  data read data valid
- dm_rsp_data  out  DATA_W  data read data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory can accept a request
- mem_req_addr  out  ADDR_W  memory address
- mem_req_we  out  1  memory write enable
- mem_req_be  out  DATA_W/8  memory byte enables
- mem_req_wdata  out  DATA_W  memory write data
- mem_rsp_data  in  DATA_W  read data, valid 1 cycle after an accepted read

Behaviour:
- Reset (rst == 0 at posedge):
  - starve_cnt = 0, rsp_owner = NONE.
  - if_rsp_valid = 0, dm_rsp_valid = 0.
  - Request-side outputs are combinational and read 0 whenever no request is valid.
- Grant decision is combinational each cycle and is evaluated only when mem_req_ready = 1. When mem_req_ready = 0: no grant, both *_req_ready = 0, mem_req_valid = 0.
  - dm_req_valid && !(if_req_valid && starve_cnt == MAX_STARVE) -> grant DM.
  - Otherwise, if_req_valid -> grant IF.
  - Neither valid -> idle.
- Granted requester sees *_req_ready = 1 in the same cycle. mem_req_* is muxed from that requester.
- IF grants drive mem_req_we = 0 and mem_req_be = all ones.
- Handshake rules:
  - Requesters hold valid and payload stable until ready.
  - The arbiter never drops or reorders an accepted request.
- starve_cnt, updated at posedge:
  - cleared on IF grant, or when if_req_valid = 0;
  - otherwise incremented when if_req_valid && DM granted && mem_req_ready;
  - saturates at MAX_STARVE;
  - unchanged while mem_req_ready = 0.
- rsp_owner, a registered FSM with states NONE / IF / DM:
  - next state = IF after an accepted IF read;
  - next state = DM after an accepted DM read (dm_req_we = 0);
  - next state = NONE after a write or an idle cycle.
- Response, cycle after grant:
  - owner == IF -> if_rsp_valid = 1 and if_rsp_data = mem_rsp_data;
  - owner == DM -> dm_rsp_valid = 1 and dm_rsp_data = mem_rsp_data;
  - the non-owner's rsp_valid = 0, and its rsp_data is held at its last value.
- Throughput: back-to-back grants are legal every cycle. A response and the next grant may coincide.
- Writes produce no response.
- Reset asserted while a read is outstanding: the response is discarded and both rsp_valid outputs are 0 in the cycle after reset.

Optional Feature:
- Macro: RV_MEM_ARB_STATS_EN.
- When defined, adds three 32-bit wrapping counters, all cleared on reset:
  - stat_if_gnt, counting IF grants;
  - stat_dm_gnt, counting DM grants;
  - stat_conflict, counting cycles with both requests valid and mem_req_ready = 1.
- The counters are exposed as extra output ports.
- When undefined, these ports and registers do not exist and arbitration behaviour is identical.

Decomposition:
- rv_pkg adds:
  - typedef enum rsp_owner_t {OWN_NONE, OWN_IF, OWN_DM};
  - struct mem_req_t {addr, we, be, wdata}, reused for the mem_req_* bundle;
  - constant MEM_RD_LATENCY = 1.
- One natural sub-module: rv_mem_arb_starve, holding the saturating starvation counter with increment and clear inputs and an at_max output.

Test Plan:
1. IF only, reads at 0x00, 0x04, 0x08 on consecutive cycles, mem_req_ready = 1 -> if_req_ready = 1 every cycle; if_rsp_valid = 1 one cycle later with the matching data each cycle.
2. Both valid for 10 cycles with MAX_STARVE = 4 -> grant sequence DM, DM, DM, DM, IF, DM, DM, DM, DM, IF; starve_cnt reaches 4 and then clears.
3. DM write of 0xDEADBEEF to 0x100 with be = 4'b0011, then DM read of 0x100 -> no dm_rsp_valid for the write; mem_req_be = 0011 on the write cycle; dm_rsp_valid = 1 for the read with the memory-model data.
4. mem_req_ready held 0 for 3 cycles with both requests valid -> no grants, starve_cnt unchanged, responses 0; normal arbitration resumes when mem_req_ready returns to 1.
5. rst driven to 0 the cycle after an accepted IF read -> if_rsp_valid = 0 in the following cycle, starve_cnt = 0, rsp_owner = NONE.
6. With RV_MEM_ARB_STATS_EN defined, run scenario 2 -> stat_dm_gnt = 8, stat_if_gnt = 2, stat_conflict = 10.
